// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// Result and carry are registered and held until the next op.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_res_next;

  // one full-adder slice on the current LSBs
  always_comb begin
    w_s  = r_a[0] ^ r_b[0] ^ r_c;
    w_co = (r_a[0] & r_b[0]) |
           (r_a[0] & r_c) |
           (r_b[0] & r_c);
    w_res_next = r_res |
                 (WIDTH'(w_s) << r_cnt);
  end

  // control FSM plus datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub;
            r_cnt   <= '0;
            r_res   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_co;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            sum     <= w_res_next;
            carry   <= w_co;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1.
// Expected results are hand-computed constants.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done, carry;
  logic [7:0] sum;

  logic       start1, sub1, a1, b1;
  logic       busy1, done1, carry1, sum1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] hold_sum;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .start(start), .sub(sub),
    .a(a), .b(b),
    .busy(busy), .done(done),
    .sum(sum), .carry(carry)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .start(start1), .sub(sub1),
    .a(a1), .b(b1),
    .busy(busy1), .done(done1),
    .sum(sum1), .carry(carry1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // one full 8-bit op; inj pulses a stray start
  // in RUN cycle 3 and in the DONE cycle
  task automatic run8(input string tag,
                      input logic s,
                      input logic [7:0] va,
                      input logic [7:0] vb,
                      input logic [7:0] es,
                      input logic ec,
                      input bit inj);
    @(negedge clk);
    start = 1'b1; sub = s; a = va; b = vb;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      sub = ~s; a = ~va; b = 8'h5A;
      if (inj && i == 2) begin
        start = 1'b1; sub = 1'b0;
        a = 8'hFF; b = 8'hFF;
      end
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_nodone"}, done, 1'b0);
      chk({tag, "_hold"}, sum, hold_sum);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy0"}, busy, 1'b0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_carry"}, carry, ec);
    hold_sum = es;
    if (inj) begin
      start = 1'b1; a = 8'hFF; b = 8'hFF;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_pulse1"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_after"}, sum, es);
    if (inj) begin
      @(negedge clk);
      chk({tag, "_ignored"}, busy, 1'b0);
      chk({tag, "_nodone2"}, done, 1'b0);
      chk({tag, "_keep"}, sum, es);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; sub = 1'b0;
    a = 8'h3C; b = 8'h0F;
    start1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    hold_sum = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst1_busy", busy1, 1'b0);
    rst_n = 1'b1; start = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("rst_nostart", busy, 1'b0);

    run8("add", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);
    run8("wrap", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run8("sub57", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run8("sub75", 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
    run8("ign", 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b1);

    // abort mid-run with reset
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'hAA; b = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy0", busy, 1'b0);
    chk("abort_done0", done, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_carry", carry, 1'b0);
    hold_sum = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_quiet", {busy, done}, 2'b00);
    end
    run8("post", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

    // WIDTH=1 registered full adder
    @(negedge clk);
    start1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    chk("w1_busy", busy1, 1'b1);
    chk("w1_nodone", done1, 1'b0);
    @(negedge clk);
    chk("w1_done", done1, 1'b1);
    chk("w1_sum11", sum1, 1'b0);
    chk("w1_carry11", carry1, 1'b1);
    @(negedge clk);
    chk("w1_pulse", done1, 1'b0);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("w1_done2", done1, 1'b1);
    chk("w1_sum10", sum1, 1'b1);
    chk("w1_carry10", carry1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
